// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
//   Shared types and constants for the rename-stage physical-register free list.
//   Also provides default rename/commit group widths when the surrounding
//   build has not already defined them through config.svh.
//
//   Contents:
//     ARCH_REG_NUM  number of architectural registers (pregs 0..31 start mapped)
//     preg_t        physical register index for the default 64-entry file
//     init_preg()   preg held by free-list slot k right after reset
// -----------------------------------------------------------------------------
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package free_list_pkg;

  localparam int ARCH_REG_NUM    = 32;
  localparam int PHY_REG_NUM_DEF = 64;
  localparam int PW_DEF          = $clog2(PHY_REG_NUM_DEF);

  typedef logic [PW_DEF-1:0] preg_t;

  // After reset the first PHY_REG_NUM-32 slots hold pregs 32, 33, ... because
  // pregs 0..31 back the initial architectural mapping.
  function automatic int init_preg(input int k);
    return ARCH_REG_NUM + k;
  endfunction

endpackage

// File: rtl/free_list_prefix_count.sv
// -----------------------------------------------------------------------------
// prefix_count
//   Exclusive prefix popcount of a request vector plus its total popcount.
//   o_prefix[i] = number of set bits in i_bits[i-1:0]; o_total = popcount.
//
//   Ports:
//     i_bits    in   W        request mask
//     o_prefix  out  W x CNTW exclusive prefix counts
//     o_total   out  CNTW     total number of set bits
// -----------------------------------------------------------------------------
module prefix_count #(
  parameter int W    = 4,
  parameter int CNTW = $clog2(W + 1)
) (
  input  logic [W-1:0]    i_bits,
  output logic [CNTW-1:0] o_prefix [W],
  output logic [CNTW-1:0] o_total
);

  logic [CNTW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < W; i++) begin
      o_prefix[i] = w_acc;
      w_acc       = w_acc + CNTW'(i_bits[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list for the rename stage. A circular buffer of
//   free pregs with three pointers:
//     head       speculative allocation point (rename)
//     arch_head  allocation point as seen by committed state
//     tail       insertion point for pregs released at commit
//   A flush rolls head back to arch_head in a single cycle.
//
//   Optional feature (macro FREE_LIST_CHECK_EN): keeps a per-preg "in list"
//   bit vector and raises a sticky error_o when commit releases a preg that is
//   already free. Without the macro error_o is tied low.
//
//   Ports:
//     clk             in   1                 clock
//     rst_n           in   1                 asynchronous active-low reset
//     alloc_req_i     in   DECODE_WIDTH      slot i needs a destination preg
//     alloc_valid_i   in   1                 rename group valid
//     alloc_ready_o   out  1                 whole group can be granted
//     preg_o          out  DECODE_WIDTH x PW preg for slot i (valid where requested)
//     commit_valid_i  in   COMMIT_WIDTH      commit slot i releases a preg
//     free_preg_i     in   COMMIT_WIDTH x PW preg released by commit slot i
//     restore_i       in   1                 flush: drop speculative allocations
//     free_cnt_o      out  PW+1              number of free entries
//     error_o         out  1                 sticky double-free flag
// -----------------------------------------------------------------------------
module free_list
  import free_list_pkg::*;
#(
  parameter int PHY_REG_NUM = 64,
  parameter int PW          = $clog2(PHY_REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [`DECODE_WIDTH-1:0]         alloc_req_i,
  input  logic                             alloc_valid_i,
  output logic                             alloc_ready_o,
  output logic [`DECODE_WIDTH-1:0][PW-1:0] preg_o,
  input  logic [`COMMIT_WIDTH-1:0]         commit_valid_i,
  input  logic [`COMMIT_WIDTH-1:0][PW-1:0] free_preg_i,
  input  logic                             restore_i,
  output logic [PW:0]                      free_cnt_o,
  output logic                             error_o
);

  localparam int DW       = `DECODE_WIDTH;
  localparam int CW       = `COMMIT_WIDTH;
  localparam int DCW      = $clog2(DW + 1);
  localparam int CCW      = $clog2(CW + 1);
  localparam int INIT_CNT = PHY_REG_NUM - ARCH_REG_NUM;

  logic [PW-1:0]  r_fifo [PHY_REG_NUM];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_arch_head;
  logic [PW-1:0]  r_tail;

  logic [DCW-1:0] w_alloc_pre [DW];
  logic [DCW-1:0] w_n_alloc;
  logic [CCW-1:0] w_free_pre [CW];
  logic [CCW-1:0] w_n_free;

  logic [PW-1:0]  w_alloc_off [DW];
  logic [PW-1:0]  w_free_off [CW];
  logic [PW-1:0]  w_n_alloc_ext;
  logic [PW-1:0]  w_n_free_ext;
  logic [PW-1:0]  w_count;
  logic [PW-1:0]  w_arch_nxt;
  logic           w_fire;

  prefix_count #(.W(DW), .CNTW(DCW)) u_alloc_pc (
    .i_bits   (alloc_req_i),
    .o_prefix (w_alloc_pre),
    .o_total  (w_n_alloc)
  );

  prefix_count #(.W(CW), .CNTW(CCW)) u_free_pc (
    .i_bits   (commit_valid_i),
    .o_prefix (w_free_pre),
    .o_total  (w_n_free)
  );

  always_comb begin
    for (int i = 0; i < DW; i++) w_alloc_off[i] = {{(PW-DCW){1'b0}}, w_alloc_pre[i]};
    for (int i = 0; i < CW; i++) w_free_off[i]  = {{(PW-CCW){1'b0}}, w_free_pre[i]};
  end

  assign w_n_alloc_ext = {{(PW-DCW){1'b0}}, w_n_alloc};
  assign w_n_free_ext  = {{(PW-CCW){1'b0}}, w_n_free};

  // Occupancy never exceeds PHY_REG_NUM-32, so the modular difference of the
  // pointers is never ambiguous between "full" and "empty".
  assign w_count    = r_tail - r_head;
  assign free_cnt_o = {1'b0, w_count};

  // Architectural head after this cycle's commits; also the restore target.
  assign w_arch_nxt = r_arch_head + w_n_free_ext;

  assign alloc_ready_o = ({1'b0, w_count} >= {{(PW+1-DCW){1'b0}}, w_n_alloc}) & ~restore_i;
  assign w_fire        = alloc_valid_i & alloc_ready_o;

  // Requested slots are packed densely: slot i reads the entry at head plus
  // the number of requesting slots below it.
  always_comb begin
    for (int i = 0; i < DW; i++) preg_o[i] = r_fifo[r_head + w_alloc_off[i]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PHY_REG_NUM; k++)
        r_fifo[k] <= (k < INIT_CNT) ? PW'(init_preg(k)) : '0;
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= PW'(INIT_CNT);
    end else begin
      for (int i = 0; i < CW; i++)
        if (commit_valid_i[i]) r_fifo[r_tail + w_free_off[i]] <= free_preg_i[i];
      r_tail      <= r_tail + w_n_free_ext;
      r_arch_head <= w_arch_nxt;
      // Restore wins over allocation; alloc_ready_o is already low then.
      if (restore_i)   r_head <= w_arch_nxt;
      else if (w_fire) r_head <= r_head + w_n_alloc_ext;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [PHY_REG_NUM-1:0] r_in_list;
  logic [PHY_REG_NUM-1:0] w_in_list_nxt;
  logic [PHY_REG_NUM-1:0] w_chk;
  logic                   r_error;
  logic                   w_err_hit;
  logic [PW-1:0]          w_ofs;
  logic [PW-1:0]          w_span;

  assign w_span = r_tail - w_arch_nxt;

  always_comb begin
    // Double-free detection looks at the vector as it stood at the start of
    // the cycle, plus earlier slots of the same commit group.
    w_chk     = r_in_list;
    w_err_hit = 1'b0;
    for (int i = 0; i < CW; i++) begin
      if (commit_valid_i[i]) begin
        if (w_chk[free_preg_i[i]]) w_err_hit = 1'b1;
        w_chk[free_preg_i[i]] = 1'b1;
      end
    end

    w_in_list_nxt = r_in_list;
    w_ofs         = '0;
    if (w_fire) begin
      for (int i = 0; i < DW; i++)
        if (alloc_req_i[i]) w_in_list_nxt[preg_o[i]] = 1'b0;
    end
    for (int i = 0; i < CW; i++)
      if (commit_valid_i[i]) w_in_list_nxt[free_preg_i[i]] = 1'b1;
    // Every slot from the restored head up to the current tail is free again.
    if (restore_i) begin
      for (int k = 0; k < PHY_REG_NUM; k++) begin
        w_ofs = PW'(k) - w_arch_nxt;
        if (w_ofs < w_span) w_in_list_nxt[r_fifo[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PHY_REG_NUM; k++) r_in_list[k] <= (k >= ARCH_REG_NUM);
      r_error <= 1'b0;
    end else begin
      r_in_list <= w_in_list_nxt;
      if (w_err_hit) r_error <= 1'b1;
    end
  end

  assign error_o = r_error;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

module tb_free_list;

  localparam int N  = 64;
  localparam int PW = 6;
  localparam int DW = `DECODE_WIDTH;
  localparam int CW = `COMMIT_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [DW-1:0]          alloc_req_i = '0;
  logic                   alloc_valid_i = 1'b0;
  logic                   alloc_ready_o;
  logic [DW-1:0][PW-1:0]  preg_o;
  logic [CW-1:0]          commit_valid_i = '0;
  logic [CW-1:0][PW-1:0]  free_preg_i = '0;
  logic                   restore_i = 1'b0;
  logic [PW:0]            free_cnt_o;
  logic                   error_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: free pregs in allocation order, speculatively allocated
  // pregs oldest first, and pregs currently owned by architectural state.
  int free_q[$];
  int spec_q[$];
  int arch_q[$];
  bit exp_err;

  always #5 clk = ~clk;

  free_list #(.PHY_REG_NUM(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_req_i    (alloc_req_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .preg_o         (preg_o),
    .commit_valid_i (commit_valid_i),
    .free_preg_i    (free_preg_i),
    .restore_i      (restore_i),
    .free_cnt_o     (free_cnt_o),
    .error_o        (error_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    free_q.delete(); spec_q.delete(); arch_q.delete();
    for (int k = 0; k < N - 32; k++) free_q.push_back(32 + k);
    for (int k = 0; k < 32; k++) arch_q.push_back(k);
    exp_err = 1'b0;
  endtask

  // Called just after a posedge; asserts reset without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req_i = '0; alloc_valid_i = 1'b0; commit_valid_i = '0; restore_i = 1'b0;
    #2;
    model_reset();
    check("rst_free_cnt", free_cnt_o, N - 32);
    check("rst_error", error_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic do_cycle(input logic [DW-1:0] req, input logic valid,
                          input logic [CW-1:0] cv, input int fp [CW], input logic rs);
    int n, k, p, idx;
    bit exp_ready, fire;
    int freed[$];
    int seen[$];
    alloc_req_i = req; alloc_valid_i = valid; commit_valid_i = cv; restore_i = rs;
    for (int i = 0; i < CW; i++) free_preg_i[i] = PW'(fp[i]);
    #1;
    n = $countones(req);
    exp_ready = (free_q.size() >= n) && !rs;
    check("alloc_ready", alloc_ready_o, exp_ready);
    check("free_cnt", free_cnt_o, free_q.size());
    check("error", error_o, exp_err);
    k = 0;
    for (int i = 0; i < DW; i++) begin
      if (req[i]) begin
        if (k < free_q.size()) check("preg_o", preg_o[i], free_q[k]);
        k++;
      end
    end
`ifdef FREE_LIST_CHECK_EN
    for (int i = 0; i < CW; i++) begin
      if (cv[i]) begin
        if (in_q(free_q, fp[i]) || in_q(seen, fp[i])) exp_err = 1'b1;
        seen.push_back(fp[i]);
      end
    end
`endif
    fire = valid && exp_ready;
    if (fire) repeat (n) spec_q.push_back(free_q.pop_front());
    for (int i = 0; i < CW; i++) begin
      if (cv[i]) begin
        p = spec_q.pop_front();
        idx = -1;
        foreach (arch_q[j]) if (arch_q[j] == fp[i] && idx < 0) idx = j;
        if (idx >= 0) arch_q.delete(idx);
        arch_q.push_back(p);
        freed.push_back(fp[i]);
      end
    end
    if (rs) while (spec_q.size() > 0) free_q.push_front(spec_q.pop_back());
    foreach (freed[i]) free_q.push_back(freed[i]);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    int z [CW];
    z = '{default: 0};
    repeat (cycles) do_cycle('0, 1'b0, '0, z, 1'b0);
  endtask

  initial begin
    int z [CW];
    int fp [CW];
    logic [DW-1:0] req;
    logic [CW-1:0] cv;
    int tmp[$];
    int idx;
    z = '{default: 0};

    @(posedge clk); #1;

    // Full group from reset gets 32..35.
    do_reset();
    alloc_req_i = 4'b1111; #1;
    check("t1_preg0", preg_o[0], 32);
    check("t1_preg3", preg_o[3], 35);
    do_cycle(4'b1111, 1'b1, '0, z, 1'b0);
    check("t1_cnt", free_cnt_o, 28);
    idle(1);

    // Sparse mask packs onto consecutive entries.
    do_reset();
    alloc_req_i = 4'b1010; #1;
    check("t2_preg1", preg_o[1], 32);
    check("t2_preg3", preg_o[3], 33);
    do_cycle(4'b1010, 1'b1, '0, z, 1'b0);
    do_cycle(4'b0001, 1'b1, '0, z, 1'b0);

    // Exhaust, empty-list behaviour, then reuse of committed frees.
    do_reset();
    repeat (8) do_cycle(4'b1111, 1'b1, '0, z, 1'b0);
    check("t3_cnt0", free_cnt_o, 0);
    do_cycle(4'b0001, 1'b1, '0, z, 1'b0);
    do_cycle(4'b0000, 1'b1, '0, z, 1'b0);
    fp = '{5, 9, 0, 0};
    do_cycle('0, 1'b0, 4'b0011, fp, 1'b0);
    alloc_req_i = 4'b0011; #1;
    check("t3_preg0", preg_o[0], 5);
    check("t3_preg1", preg_o[1], 9);
    do_cycle(4'b0011, 1'b1, '0, z, 1'b0);

    // Restore together with commits.
    do_reset();
    do_cycle(4'b1111, 1'b1, '0, z, 1'b0);
    do_cycle(4'b1111, 1'b1, '0, z, 1'b0);
    fp = '{1, 2, 3, 0};
    do_cycle(4'b0001, 1'b1, 4'b0111, fp, 1'b1);
    alloc_req_i = 4'b0001; #1;
    check("t4_preg0", preg_o[0], 35);
    check("t4_cnt", free_cnt_o, 32);
    do_cycle(4'b0001, 1'b1, '0, z, 1'b0);

    // Simultaneous allocation and release at low occupancy.
    do_reset();
    repeat (7) do_cycle(4'b1111, 1'b1, '0, z, 1'b0);
    do_cycle(4'b0011, 1'b1, '0, z, 1'b0);
    fp = '{10, 11, 0, 0};
    do_cycle(4'b0011, 1'b1, 4'b0011, fp, 1'b0);
    check("t5_cnt", free_cnt_o, 2);
    alloc_req_i = 4'b0011; #1;
    check("t5_preg0", preg_o[0], 10);
    check("t5_preg1", preg_o[1], 11);
    do_cycle(4'b0011, 1'b1, '0, z, 1'b0);

`ifdef FREE_LIST_CHECK_EN
    // Releasing a preg that is still free is a sticky error.
    do_reset();
    do_cycle(4'b0001, 1'b1, '0, z, 1'b0);
    fp = '{40, 0, 0, 0};
    do_cycle('0, 1'b0, 4'b0001, fp, 1'b0);
    check("t6_err_set", error_o, 1);
    idle(3);
    check("t6_err_sticky", error_o, 1);
`endif

    // Randomized traffic with flushes and one asynchronous reset midway.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      req = DW'($urandom_range(0, (1 << DW) - 1));
      cv  = CW'($urandom_range(0, (1 << CW) - 1));
      while ($countones(cv) > spec_q.size()) cv = cv & (cv - 1'b1);
      tmp = arch_q;
      fp = '{default: 0};
      for (int i = 0; i < CW; i++) begin
        if (cv[i]) begin
          idx = $urandom_range(0, tmp.size() - 1);
          fp[i] = tmp[idx];
          tmp.delete(idx);
        end
      end
      do_cycle(req, ($urandom_range(0, 7) != 0), cv, fp, ($urandom_range(0, 15) == 0));
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
